fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side drain engine for a first-word-fall-through FIFO read port (rd_data shows head while !empty).
//  Pops words and presents them as a valid/ready stream with a 2-entry elastic buffer.
//  fifo_rd_en never depends combinationally on m_tready.
//  Frames the stream into PACKET_LEN-word packets (m_tlast), flags mid-packet underruns, counts delivered words.
//  Sits in the FIFO read clock domain between fifo_async (rd_* side) and downstream consumers.
// PARAMETERS
//  DATA_WIDTH   16  width of FIFO word and m_tdata
//  PACKET_LEN   16  words per packet; m_tlast on word PACKET_LEN-1; 0 = never assert m_tlast
//  COUNT_WIDTH  32  width of words_out counter
// PORTS
//  clk           in   1           read-side clock (same clock as FIFO rd_clk)
//  rst           in   1           synchronous, active-high reset
//  fifo_rd_data  in   DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0
//  fifo_empty    in   1           FIFO empty flag
//  fifo_rd_en    out  1           pop request; asserted only when fifo_empty=0
//  m_tdata       out  DATA_WIDTH  stream data
//  m_tvalid      out  1           stream valid
//  m_tready      in   1           stream ready
//  m_tlast       out  1           last word of packet
//  flush         in   1           drop buffered words, restart packet framing
//  underrun      out  1           sticky: consumer starved mid-packet
//  words_out     out  COUNT_WIDTH words accepted downstream (tvalid&tready), wraps modulo 2^COUNT_WIDTH
// BEHAVIOUR
//  Reset (rst=1 at posedge): occ=0, in_idx=0, out_idx=0, underrun=0, words_out=0.
//   Outputs during reset: m_tvalid=0, m_tlast=0, fifo_rd_en=0; m_tdata don't-care.
//  Buffer: 2-entry FIFO of {last, data}; occupancy occ in {0,1,2}.
//   pop = m_tvalid & m_tready; push = fifo_rd_en.
//  fifo_rd_en = !rst & !flush & !fifo_empty & (occ != 2). Registered-only terms: no m_tready path.
//  Push captures fifo_rd_data and last = (PACKET_LEN!=0 && in_idx==PACKET_LEN-1).
//   in_idx increments on each push; wraps to 0 after PACKET_LEN-1.
//  Occupancy update: occ_next = occ + push - pop.
//   Sustained rate: occ=1 with push&pop every cycle => 1 word/clk.
//   When occ=2, no push that cycle, even if pop occurs.
//  m_tvalid = (occ!=0); m_tdata/m_tlast = head entry.
//   Head stays stable while m_tvalid & !m_tready.
//  Latency: fifo_empty falls in cycle t, occ=0 => fifo_rd_en=1 in t; m_tvalid=1 in t+1 with that word.
//  out_idx: increments on pop; wraps after PACKET_LEN-1, or on pop of a last entry.
//   Held at 0 when PACKET_LEN=0.
//  underrun: set when occ==0 & m_tready & out_idx!=0 & !flush.
//   Cleared only by rst or flush. Never set at a packet boundary.
//  words_out: +1 on every pop, including a pop in a flush cycle.
//  flush (one or more cycles):
//   - fifo_rd_en=0.
//   - A handshake occurring that cycle completes and is counted.
//   - Next edge: occ=0, in_idx=0, out_idx=0, underrun=0.
//   - FIFO contents are NOT drained.
//  Simultaneous push & pop at occ=1: head replaced by the new word; occ stays 1.
//  Simultaneous push & pop at occ=2: cannot happen (no push).
//  rst mid-packet: identical to flush plus words_out cleared.
//  No X propagation: buffer data regs need no reset; valid bits are reset.
// STRUCTURE
//  Shared header fifo_defs.vh: `define FIFO_OCC_W 2 and occupancy encodings OCC_EMPTY/OCC_ONE/OCC_FULL.
//  Sub-module stream_skid_2 (2-entry buffer: push/data in, valid/ready/data out, flush, occ out).
//   Parameterised by payload width (DATA_WIDTH+1).
//  Top level holds in_idx/out_idx counters, underrun, words_out, fifo_rd_en logic.
// TESTING
//  T1 reset: rst=1 3 clk with fifo_empty=0
//     -> fifo_rd_en=0, m_tvalid=0, underrun=0, words_out=0 throughout.
//  T2 streaming: FIFO model holds 0x0001..0x0020, m_tready=1, PACKET_LEN=16
//     -> 1 word/clk after 1-cycle latency; m_tlast on 0x0010 and 0x0020; words_out=32.
//  T3 backpressure: m_tready=0 for 5 clk mid-stream
//     -> occ reaches 2, fifo_rd_en=0, m_tdata stable; on release no word lost/duplicated, order intact.
//  T4 underrun: empty FIFO after word 5 of packet, m_tready=1
//     -> underrun=1 next clk and stays 1; starve at packet boundary (after word 16) -> underrun stays 0.
//  T5 flush: occ=2, flush=1 for 1 clk with m_tready=1
//     -> head counted (words_out+1), then occ=0, underrun=0; next push gets in_idx=0.
//  T6 PACKET_LEN=0, 40 words random m_tready
//     -> m_tlast never 1; output sequence equals input sequence.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg
//   Shared definitions for the FIFO read-side drain engine.
//   - FIFO_OCC_W / occ_e : occupancy width and encodings of the 2-entry
//                          elastic buffer (empty, one word, full).
//   - idx_width()        : width of the packet word index for a given
//                          packet length (never less than 1 bit).
package fifo_stream_reader_pkg;

  localparam int FIFO_OCC_W = 2;

  typedef enum logic [FIFO_OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic int idx_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/stream_skid_2.sv
// stream_skid_2
//   Two-entry elastic buffer between a push-only producer and a
//   valid/ready consumer. Entry 0 is always the head. The producer must
//   not push while full; a push seen while full is ignored.
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset (empties the buffer)
//   flush      in   synchronous drop of all buffered entries
//   push       in   write push_data this cycle
//   push_data  in   WIDTH payload
//   out_valid  out  head entry present
//   out_ready  in   consumer accepts head
//   out_data   out  head payload
//   occ        out  current occupancy
//
// state     | meaning
// OCC_EMPTY | no entry, out_valid low
// OCC_ONE   | head valid, tail unused
// OCC_FULL  | head and tail valid, producer stalled
module stream_skid_2
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output occ_e             occ
);

  occ_e             occ_q;
  occ_e             occ_d;
  logic [WIDTH-1:0] slot0_q;
  logic [WIDTH-1:0] slot1_q;
  logic             pop;
  logic             push_ok;

  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = slot0_q;
  assign occ       = occ_q;
  assign pop       = out_valid & out_ready;
  assign push_ok   = push & (occ_q != OCC_FULL);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= OCC_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push_ok) occ_d = OCC_ONE;
      end
      OCC_ONE: begin
        if (push_ok && !pop) begin
          occ_d = OCC_FULL;
        end else if (!push_ok && pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) occ_d = OCC_ONE;
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // Payload registers carry no reset: occupancy alone decides validity.
  // With one entry and a simultaneous push/pop the new word replaces the
  // head directly so a single entry sustains one word per clock.
  always_ff @(posedge clk) begin
    case (occ_q)
      OCC_EMPTY: begin
        if (push_ok) slot0_q <= push_data;
      end
      OCC_ONE: begin
        if (push_ok && pop) begin
          slot0_q <= push_data;
        end else if (push_ok) begin
          slot1_q <= push_data;
        end
      end
      OCC_FULL: begin
        if (pop) slot0_q <= slot1_q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Drains a first-word-fall-through FIFO read port into a valid/ready
//   stream through a 2-entry elastic buffer. The pop request depends only
//   on registered state, the FIFO flag and flush, never on m_tready.
//   Frames the stream into PACKET_LEN-word packets via m_tlast, raises a
//   sticky underrun when the consumer is starved mid-packet, and counts
//   delivered words.
// Parameters
//   DATA_WIDTH   FIFO word / m_tdata width
//   PACKET_LEN   words per packet, 0 disables m_tlast
//   COUNT_WIDTH  width of words_out
// Ports
//   clk           in   read-side clock
//   rst           in   synchronous active-high reset
//   fifo_rd_data  in   FIFO head word, valid while fifo_empty is low
//   fifo_empty    in   FIFO empty flag
//   fifo_rd_en    out  pop request, only while fifo_empty is low
//   m_tdata       out  stream data
//   m_tvalid      out  stream valid
//   m_tready      in   stream ready
//   m_tlast       out  last word of packet
//   flush         in   drop buffered words, restart framing
//   underrun      out  sticky consumer-starved-mid-packet flag
//   words_out     out  accepted-word counter, wraps
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int PACKET_LEN  = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  input  logic                   flush,
  output logic                   underrun,
  output logic [COUNT_WIDTH-1:0] words_out
);

  localparam int IDX_W = idx_width(PACKET_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'((PACKET_LEN == 0) ? 0 : PACKET_LEN - 1);

  logic [IDX_W-1:0]  in_idx_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic              push;
  logic              pop;
  logic              in_last;
  logic              head_last;
  logic              skid_valid;
  logic [DATA_WIDTH:0] skid_dout;
  occ_e              occ;

  assign fifo_rd_en = !rst && !flush && !fifo_empty && (occ != OCC_FULL);
  assign push       = fifo_rd_en;

  // The last flag travels with the word so framing survives backpressure.
  assign in_last = (PACKET_LEN != 0) && (in_idx_q == LAST_IDX);

  stream_skid_2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({in_last, fifo_rd_data}),
    .out_valid (skid_valid),
    .out_ready (m_tready & !rst),
    .out_data  (skid_dout),
    .occ       (occ)
  );

  assign m_tvalid  = skid_valid & !rst;
  assign m_tdata   = skid_dout[DATA_WIDTH-1:0];
  assign head_last = skid_dout[DATA_WIDTH];
  assign m_tlast   = m_tvalid & head_last;
  assign pop       = m_tvalid & m_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx_q  <= '0;
      out_idx_q <= '0;
      underrun  <= 1'b0;
      words_out <= '0;
    end else begin
      // A handshake in a flush cycle still completes and is counted.
      if (pop) words_out <= words_out + COUNT_WIDTH'(1);

      if (flush) begin
        in_idx_q  <= '0;
        out_idx_q <= '0;
        underrun  <= 1'b0;
      end else begin
        if (push) begin
          if ((PACKET_LEN == 0) || in_last) begin
            in_idx_q <= '0;
          end else begin
            in_idx_q <= in_idx_q + IDX_W'(1);
          end
        end

        if (pop) begin
          if ((PACKET_LEN == 0) || head_last || (out_idx_q == LAST_IDX)) begin
            out_idx_q <= '0;
          end else begin
            out_idx_q <= out_idx_q + IDX_W'(1);
          end
        end

        // out_idx is zero on a packet boundary, so starving there is fine.
        if ((occ == OCC_EMPTY) && m_tready && (out_idx_q != '0)) begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        flush_b;
  logic [15:0] fifo_rd_data_a, fifo_rd_data_b;
  logic        fifo_empty_a, fifo_empty_b;
  logic        fifo_rd_en_a, fifo_rd_en_b;
  logic [15:0] m_tdata_a, m_tdata_b;
  logic        m_tvalid_a, m_tvalid_b;
  logic        ready_a, ready_b;
  logic        m_tlast_a, m_tlast_b;
  logic        underrun_a, underrun_b;
  logic [31:0] words_out_a, words_out_b;

  fifo_stream_reader #(.DATA_WIDTH(16), .PACKET_LEN(16), .COUNT_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .fifo_rd_data(fifo_rd_data_a), .fifo_empty(fifo_empty_a),
    .fifo_rd_en(fifo_rd_en_a), .m_tdata(m_tdata_a), .m_tvalid(m_tvalid_a),
    .m_tready(ready_a), .m_tlast(m_tlast_a), .flush(flush), .underrun(underrun_a),
    .words_out(words_out_a)
  );

  fifo_stream_reader #(.DATA_WIDTH(16), .PACKET_LEN(0), .COUNT_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .fifo_rd_data(fifo_rd_data_b), .fifo_empty(fifo_empty_b),
    .fifo_rd_en(fifo_rd_en_b), .m_tdata(m_tdata_b), .m_tvalid(m_tvalid_b),
    .m_tready(ready_b), .m_tlast(m_tlast_b), .flush(flush_b), .underrun(underrun_b),
    .words_out(words_out_b)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] fq_a[$];
  logic [15:0] fq_b[$];
  ent_t        exp_q[$];
  logic [15:0] dummy;
  int          in_cnt, out_cnt, nb;
  logic        und_m;
  logic [31:0] wcnt;
  logic        take_a, take_b;
  logic        chk_en, t6_on;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty_a   = (fq_a.size() == 0);
    fifo_rd_data_a = fifo_empty_a ? 16'h0 : fq_a[0];
    fifo_empty_b   = (fq_b.size() == 0);
    fifo_rd_data_b = fifo_empty_b ? 16'h0 : fq_b[0];
  endtask

  // Reference behaviour for the PACKET_LEN=16 instance; exp_q holds the
  // words that should be sitting in the elastic buffer, head first.
  task automatic monitor_a();
    int   sz;
    logic mval, mrd, hs, und_set;
    ent_t e;
    sz   = exp_q.size();
    mval = (sz != 0);
    mrd  = !rst && !flush && !fifo_empty_a && (sz != 2);
    if (chk_en) begin
      chk("tvalid", 64'(m_tvalid_a), 64'(mval));
      chk("rd_en", 64'(fifo_rd_en_a), 64'(mrd));
      chk("underrun", 64'(underrun_a), 64'(und_m));
      chk("words_out", 64'(words_out_a), 64'(wcnt));
      if (mval) begin
        chk("tdata", 64'(m_tdata_a), 64'(exp_q[0].data));
        chk("tlast", 64'(m_tlast_a), 64'(exp_q[0].last));
      end else begin
        chk("tlast_idle", 64'(m_tlast_a), 64'd0);
      end
    end
    take_a = mrd;
    if (rst) begin
      exp_q.delete();
      in_cnt = 0; out_cnt = 0; und_m = 1'b0; wcnt = '0;
    end else begin
      hs      = mval && ready_a;
      und_set = (sz == 0) && ready_a && (out_cnt != 0);
      if (hs) begin
        wcnt = wcnt + 32'd1;
        e = exp_q.pop_front();
        out_cnt = (e.last || out_cnt == 15) ? 0 : out_cnt + 1;
      end
      if (flush) begin
        exp_q.delete();
        in_cnt = 0; out_cnt = 0; und_m = 1'b0;
      end else begin
        if (und_set) und_m = 1'b1;
        if (mrd) begin
          exp_q.push_back('{last: (in_cnt == 15), data: fifo_rd_data_a});
          in_cnt = (in_cnt == 15) ? 0 : in_cnt + 1;
        end
      end
    end
  endtask

  // PACKET_LEN=0 instance: output must be 0x0101, 0x0102, ... in order.
  task automatic monitor_b();
    if (chk_en && m_tvalid_b && ready_b && !rst) begin
      chk("t6_data", 64'(m_tdata_b), 64'(16'h0101 + 16'(nb)));
      chk("t6_tlast", 64'(m_tlast_b), 64'd0);
      nb++;
    end
    if (chk_en && fifo_rd_en_b) chk("t6_rd_en_nonempty", 64'(fifo_empty_b), 64'd0);
    take_b = fifo_rd_en_b && !fifo_empty_b;
    if (rst) nb = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor_a();
    monitor_b();
    @(posedge clk);
    #1;
    if (take_a) dummy = fq_a.pop_front();
    if (take_b) dummy = fq_b.pop_front();
    if (t6_on) ready_b = 1'($urandom_range(0, 1));
    refresh();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load_a(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) fq_a.push_back(first + 16'(i));
    refresh();
  endtask

  task automatic load_b(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) fq_b.push_back(first + 16'(i));
    refresh();
  endtask

  task automatic wait_words_a(input logic [31:0] target, input int budget);
    for (int i = 0; i < budget && words_out_a != target; i++) cyc();
    chk("wait_words_a", 64'(words_out_a), 64'(target));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flush_b = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0;
    chk_en = 1'b0; t6_on = 1'b0;
    take_a = 1'b0; take_b = 1'b0;
    in_cnt = 0; out_cnt = 0; nb = 0; und_m = 1'b0; wcnt = '0;
    dummy = '0;
    load_a(16'h0001, 32);
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // T1: reset held with a non-empty FIFO
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t1_rd_en", 64'(fifo_rd_en_a), 64'd0);
      chk("t1_tvalid", 64'(m_tvalid_a), 64'd0);
      chk("t1_underrun", 64'(underrun_a), 64'd0);
      chk("t1_words", 64'(words_out_a), 64'd0);
    end

    // T2: 32 words at full rate, one cycle of latency
    rst = 1'b0;
    ready_a = 1'b1;
    cycles(33);
    chk("t2_rate", 64'(words_out_a), 64'd32);

    // T3: backpressure mid-stream
    load_a(16'h0021, 16);
    cycles(3);
    ready_a = 1'b0;
    cycles(5);
    chk("t3_rd_en_full", 64'(fifo_rd_en_a), 64'd0);
    chk("t3_tvalid", 64'(m_tvalid_a), 64'd1);
    ready_a = 1'b1;
    wait_words_a(32'd48, 40);

    // T4: starve mid-packet, then starve at a packet boundary
    load_a(16'h0031, 5);
    wait_words_a(32'd53, 20);
    cycles(3);
    chk("t4_underrun_set", 64'(underrun_a), 64'd1);
    cycles(3);
    chk("t4_underrun_sticky", 64'(underrun_a), 64'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t4_underrun_flushed", 64'(underrun_a), 64'd0);
    load_a(16'h0041, 16);
    wait_words_a(32'd69, 40);
    cycles(4);
    chk("t4_boundary_no_underrun", 64'(underrun_a), 64'd0);

    // T5: flush with a full buffer and a handshake in the same cycle
    ready_a = 1'b0;
    load_a(16'h0061, 4);
    cycles(4);
    chk("t5_full_rd_en", 64'(fifo_rd_en_a), 64'd0);
    flush = 1'b1;
    ready_a = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t5_words", 64'(words_out_a), 64'd70);
    chk("t5_underrun", 64'(underrun_a), 64'd0);
    chk("t5_tvalid", 64'(m_tvalid_a), 64'd0);
    load_a(16'h0065, 14);
    wait_words_a(32'd86, 40);

    // T6: PACKET_LEN=0, random ready
    t6_on = 1'b1;
    load_b(16'h0101, 40);
    for (int i = 0; i < 400 && words_out_b != 32'd40; i++) cyc();
    chk("t6_count", 64'(words_out_b), 64'd40);
    chk("t6_order_count", 64'(nb), 64'd40);
    chk("t6_underrun", 64'(underrun_b), 64'd0);
    t6_on = 1'b0;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
